// File: rtl/restart_pkg.sv
// Shared types and helpers for the restart sequencer.
// Holds the FSM state encoding, the source-index width and a priority encoder.
package restart_pkg;

    typedef enum logic [2:0] {
        S_SYNC,
        S_READY,
        S_PLAY,
        S_REQ,
        S_COOLDOWN
    } state_t;

    // Widest source vector the priority encoder accepts.
    localparam int MAX_SRC = 32;

    // Source index width: at least one bit, even with a single source.
    function automatic int src_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic int lowest_idx(input logic [MAX_SRC-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/restart_sequencer_hold_counter.sv
// Saturating long-press counter for one reset button.
// Raises reached once level has been high for HOLD_CYCLES enabled cycles.
module hold_counter #(
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic level,
    output logic reached
);

    localparam int W = $clog2(HOLD_CYCLES + 1);

    logic [W-1:0] cnt;

    // Count while enabled and pressed, clear otherwise, saturate at the target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || !level) begin
            cnt <= '0;
        end else if (cnt != W'(HOLD_CYCLES)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign reached = (cnt == W'(HOLD_CYCLES));

endmodule

// File: rtl/restart_sequencer.sv
// Arbitrates new-game and abort requests from several button sources.
// Optional ack timeout is enabled by defining RESTART_TIMEOUT_EN.
module restart_sequencer
    import restart_pkg::*;
#(
    parameter int          NUM_SRC         = 2,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned COOLDOWN_CYCLES = 1000,
    parameter int unsigned ACK_TIMEOUT     = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        idle_state,
    input  logic [NUM_SRC-1:0]          start_btn,
    input  logic [NUM_SRC-1:0]          reset_btn,
    input  logic                        restart_ack,
    output logic                        restart_req,
    output logic                        restart_abort,
    output logic [src_w(NUM_SRC)-1:0]   restart_src,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int SRC_W = src_w(NUM_SRC);
    localparam int CD_W  = $clog2(COOLDOWN_CYCLES + 1);

    state_t             state;
    logic [NUM_SRC-1:0] start_prev;
    logic [NUM_SRC-1:0] reset_prev;
    logic [NUM_SRC-1:0] start_rise;
    logic [NUM_SRC-1:0] reset_rise;
    logic [NUM_SRC-1:0] rise_any;
    logic [NUM_SRC-1:0] reached;
    logic               hold_en;
    logic [CD_W-1:0]    cd_cnt;

    assign start_rise = start_btn & ~start_prev;
    assign reset_rise = reset_btn & ~reset_prev;
    assign rise_any   = start_rise | reset_rise;

    // Long-press tracking only runs during play; it is cleared elsewhere.
    assign hold_en = (state == S_PLAY);

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_hold
        hold_counter #(
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_hold (
            .clk    (clk),
            .rst    (rst),
            .en     (hold_en),
            .level  (reset_btn[s]),
            .reached(reached[s])
        );
    end

    // Previous button levels; all ones so a button held through reset is no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_prev <= '1;
            reset_prev <= '1;
        end else begin
            start_prev <= start_btn;
            reset_prev <= reset_btn;
        end
    end

`ifdef RESTART_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;
`else
    logic unused_timeout;

    assign unused_timeout = |ACK_TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

    // Sequencer FSM with registered request, qualifier and busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_SYNC;
            restart_req   <= 1'b0;
            restart_abort <= 1'b0;
            restart_src   <= '0;
            busy          <= 1'b0;
            cd_cnt        <= '0;
`ifdef RESTART_TIMEOUT_EN
            to_cnt        <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
`ifdef RESTART_TIMEOUT_EN
            timeout_err <= 1'b0;
            to_cnt      <= '0;
`endif
            case (state)
                S_SYNC: begin
                    state <= idle_state ? S_READY : S_PLAY;
                end
                S_READY: begin
                    if (!idle_state) begin
                        state <= S_PLAY;
                    end else if (|rise_any) begin
                        state         <= S_REQ;
                        restart_req   <= 1'b1;
                        restart_abort <= 1'b0;
                        restart_src   <= SRC_W'(lowest_idx(MAX_SRC'(rise_any)));
                        busy          <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (|reached) begin
                        state         <= S_REQ;
                        restart_req   <= 1'b1;
                        restart_abort <= 1'b1;
                        restart_src   <= SRC_W'(lowest_idx(MAX_SRC'(reached)));
                        busy          <= 1'b1;
                    end else if (idle_state) begin
                        state <= S_READY;
                    end
                end
                S_REQ: begin
                    if (restart_ack) begin
                        state       <= S_COOLDOWN;
                        restart_req <= 1'b0;
                        cd_cnt      <= '0;
`ifdef RESTART_TIMEOUT_EN
                    end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                        state       <= S_COOLDOWN;
                        restart_req <= 1'b0;
                        timeout_err <= 1'b1;
                        cd_cnt      <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                S_COOLDOWN: begin
                    if (cd_cnt == CD_W'(COOLDOWN_CYCLES - 1)) begin
                        state <= S_SYNC;
                        busy  <= 1'b0;
                    end else begin
                        cd_cnt <= cd_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_SYNC;
                end
            endcase
        end
    end

endmodule

// File: doc/restart_sequencer.md
Name: restart_sequencer

Overview:
- Parametrised successor of the single-pulse restart logic; arbitrates restart/abort requests from NUM_SRC button sources (players/panels).
- In idle, a start or reset press requests a new game. During play, a long-press of reset requests an abort.
- Requests use a req/ack handshake with the game FSM, followed by a cooldown lockout.
- Sits between the debounced button synchronisers and the game FSM.

Parameters:
- NUM_SRC, 2, number of button sources (>=1)
- HOLD_CYCLES, 50000000, cycles reset_btn must stay high during play to abort (>=1)
- COOLDOWN_CYCLES, 1000, lockout cycles after each acknowledged request (>=1)
- ACK_TIMEOUT, 4096, max cycles restart_req waits for ack (used only with the optional feature)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- idle_state  input  1  high when game FSM is in idle/done
- start_btn  input  NUM_SRC  debounced start buttons, level, active high
- reset_btn  input  NUM_SRC  debounced reset buttons, level, active high
- restart_ack  input  1  game FSM accepts the pending request
- restart_req  output  1  request pending; held until ack
- restart_abort  output  1  valid with restart_req: 0 = new game from idle, 1 = abort of running game
- restart_src  output  SRC_W  index of winning source, valid with restart_req; SRC_W = max(1, clog2(NUM_SRC))
- busy  output  1  high in S_REQ or S_COOLDOWN
- timeout_err  output  1  one-cycle pulse on ack timeout (optional feature only; tied 0 otherwise)

Behaviour:
- Reset:
  - state = S_SYNC; all outputs 0; counters 0.
  - Previous-button registers reset to all ones, so a button held through reset does not produce an edge.
- Edge detection:
  - rise_s = btn_s & ~prev_s, evaluated separately for start and reset.
  - prev registers update every cycle in every state.
- S_SYNC: single cycle. Go to S_READY if idle_state, else S_PLAY.
- S_READY:
  - If idle_state drops, go to S_PLAY.
  - Otherwise, any rise on start_btn or reset_btn goes to S_REQ with abort=0.
  - src = lowest index with any rise. Same-cycle start and reset on one source count as one request.
- S_PLAY:
  - Start edges are ignored.
  - Per-source hold counter: increments while reset_btn[s] is high, clears to 0 when it is low. Counter saturates; width = clog2(HOLD_CYCLES+1).
  - When a counter reaches HOLD_CYCLES, go to S_REQ with abort=1 and src = lowest such index.
  - If idle_state rises with no request, go to S_READY and clear all counters.
- S_REQ:
  - restart_req=1; restart_abort and restart_src are stable for the whole state.
  - On restart_ack=1: req drops the next cycle, go to S_COOLDOWN.
  - Ack is ignored in all other states.
  - Ack in the same cycle req first rises is honoured; minimum req width is 1 cycle.
- S_COOLDOWN:
  - Counts COOLDOWN_CYCLES, then goes to S_SYNC.
  - Button edges and holds are discarded during cooldown; hold counters are held at 0.
- busy is registered and equals (state==S_REQ || state==S_COOLDOWN).
- Latency:
  - Idle request: edge on the input at cycle N gives restart_req high at N+1.
  - Abort: restart_req rises one cycle after the counter reaches HOLD_CYCLES, i.e. HOLD_CYCLES+1 cycles after reset_btn rises.
- Reset mid-operation: asserting rst in any state returns to reset values immediately (asynchronous); no partial pulse or request survives.

Optional Feature:
- RESTART_TIMEOUT_EN:
  - Defined: an ACK_TIMEOUT counter runs in S_REQ. On expiry, drop restart_req, pulse timeout_err for 1 cycle, go to S_COOLDOWN.
  - Ack on the expiry cycle wins; no error is flagged.
  - Undefined: no counter; req is held indefinitely; timeout_err is constant 0.

Decomposition:
- Package restart_pkg:
  - State enum (S_SYNC, S_READY, S_PLAY, S_REQ, S_COOLDOWN).
  - Function computing SRC_W.
  - Lowest-index priority-encode function.
- Sub-module hold_counter: one instance per source via generate. Inputs clk, rst, en, level. Output reached. Parameter HOLD_CYCLES.

Test Plan:
- NUM_SRC=2, idle_state=1, pulse start_btn[1] at cycle 10 -> restart_req=1 at cycle 11, abort=0, src=1; ack at 14 -> req=0 at 15, busy high for COOLDOWN_CYCLES more cycles.
- idle=1, start_btn[0] and reset_btn[1] rise same cycle -> single request with src=0.
- idle=0, HOLD_CYCLES=8, reset_btn[0] high 7 cycles then low -> no request; then high 8 cycles -> req with abort=1, src=0.
- Button held through rst deassertion -> no request; press during cooldown -> ignored; after cooldown, new press -> req.
- Request pending, idle_state toggles and other buttons press -> req, abort and src unchanged until ack.
- With RESTART_TIMEOUT_EN and ACK_TIMEOUT=16, no ack -> req drops after 16 cycles and timeout_err pulses once; ack on cycle 16 -> no timeout_err.
